// File: rtl/dispense_unit.sv
// Dispense unit: accepts a vend command, runs one product motor for a fixed time,
// then waits for a debounced pickup-door confirmation or reports a pickup timeout.
module dispense_unit #(
  parameter int MOTOR_CYCLES    = 50,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COLLECT_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_req,
  input  logic [1:0] vend_sel,
  output logic       vend_ack,
  output logic       vend_done,
  output logic       vend_fault,
  input  logic       fault_clr,
  input  logic       collected,
  output logic [3:0] motor_on,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] SPIN         = 2'd1;
  localparam logic [1:0] WAIT_COLLECT = 2'd2;
  localparam logic [1:0] FAULT        = 2'd3;

  localparam int MW = $clog2(MOTOR_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(COLLECT_TIMEOUT + 1);

  localparam logic [MW-1:0] MOTOR_LAST = MW'(MOTOR_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(COLLECT_TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // Door switch: two-flop synchronizer, debouncer, rising-edge pulse
  // ---------------------------------------------------------------------------
  logic          sync_1;
  logic          sync_2;
  logic          deb_level;
  logic [DW-1:0] deb_cnt;
  logic          col_rise;

  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would collapse the synchronizer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      col_rise  <= 1'b0;
    end else begin
      sync_1   <= collected;
      sync_2   <= sync_1;
      col_rise <= 1'b0;
      if (sync_2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_level <= sync_2;
        deb_cnt   <= '0;
        col_rise  <= sync_2;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vend sequencer
  // ---------------------------------------------------------------------------
  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [1:0]    sel;
  logic [1:0]    sel_n;
  logic [MW-1:0] motor_cnt;
  logic [MW-1:0] motor_cnt_n;
  logic [TW-1:0] wait_cnt;
  logic [TW-1:0] wait_cnt_n;
  logic          ack_n;
  logic          done_n;
  logic          fault_n;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_n     = state;
    sel_n       = sel;
    motor_cnt_n = motor_cnt;
    wait_cnt_n  = wait_cnt;
    ack_n       = 1'b0;
    done_n      = 1'b0;
    fault_n     = vend_fault;

    case (state)
      IDLE: begin
        if (vend_req) begin
          state_n     = SPIN;
          sel_n       = vend_sel;
          motor_cnt_n = '0;
          ack_n       = 1'b1;
        end
      end
      SPIN: begin
        if (motor_cnt == MOTOR_LAST) begin
          state_n    = WAIT_COLLECT;
          wait_cnt_n = '0;
        end else begin
          motor_cnt_n = motor_cnt + MW'(1);
        end
      end
      WAIT_COLLECT: begin
        // A fresh rise on the final timeout cycle still counts as a pickup.
        if (col_rise) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_n = FAULT;
          fault_n = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + TW'(1);
        end
      end
      FAULT: begin
        if (fault_clr) begin
          state_n = IDLE;
          fault_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        fault_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sel        <= '0;
      motor_cnt  <= '0;
      wait_cnt   <= '0;
      vend_ack   <= 1'b0;
      vend_done  <= 1'b0;
      vend_fault <= 1'b0;
      motor_on   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      motor_cnt  <= motor_cnt_n;
      wait_cnt   <= wait_cnt_n;
      vend_ack   <= ack_n;
      vend_done  <= done_n;
      vend_fault <= fault_n;
      motor_on   <= (state_n == SPIN) ? (4'b0001 << sel_n) : 4'b0000;
      busy       <= (state_n != IDLE);
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/dispense_unit.md
Name: dispense_unit

Overview:
- Mechanical-side responder for the vending FSM's vend request.
- Accepts a vend command with a product select and runs the selected product motor for a fixed time.
- Waits for a debounced "collected" confirmation from the pickup-door switch, then reports done; reports a fault if pickup times out.
- Sits between top_vending_machine's FSM (request side) and the board pins (motor outputs, collected switch).

Parameters:
- MOTOR_CYCLES, 50, clock cycles the motor output stays high per vend (>=1)
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a new collected level (>=1)
- COLLECT_TIMEOUT, 1000, cycles allowed in WAIT_COLLECT before FAULT (>=1)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- vend_req  in  1  level request from FSM, held until vend_ack is seen
- vend_sel  in  2  product index; sampled only on acceptance
- vend_ack  out  1  one-cycle pulse: request accepted
- vend_done  out  1  one-cycle pulse: product collected
- vend_fault  out  1  level: pickup timeout; held until fault_clr
- fault_clr  in  1  one-cycle pulse: clears FAULT, returns to IDLE
- collected  in  1  raw asynchronous door switch, active-high
- motor_on  out  4  one-hot motor drive, bit = latched vend_sel
- busy  out  1  high in any state other than IDLE
- state_dbg  out  2  encoded state for LEDs: IDLE=0, SPIN=1, WAIT_COLLECT=2, FAULT=3

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; motor_on=0 immediately without waiting for a clock edge; vend_ack=0, vend_done=0, vend_fault=0, busy=0, state_dbg=0; all counters, synchronizer flops and the debounced level clear to 0.
- collected path:
  - 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it.
  - col_rise is a one-cycle pulse on a debounced 0->1 transition.
  - Latency from a raw edge to col_rise is 2+DEBOUNCE_CYCLES cycles.
- IDLE:
  - On vend_req=1: latch vend_sel, pulse vend_ack on the next cycle, enter SPIN, load the motor counter.
  - The state, vend_ack and the counter load all take effect on the same edge.
- SPIN:
  - motor_on = 1<<sel for exactly MOTOR_CYCLES cycles.
  - Then motor_on=0, enter WAIT_COLLECT, clear the timeout counter.
  - col_rise in SPIN is ignored.
- WAIT_COLLECT:
  - col_rise: pulse vend_done next cycle, return to IDLE.
  - No col_rise within COLLECT_TIMEOUT cycles: enter FAULT, vend_fault=1.
  - A debounced level already high on entry does not count; a fresh rising edge is required.
- FAULT:
  - Outputs idle; vend_fault=1.
  - fault_clr returns to IDLE with vend_fault=0 on the next cycle.
  - vend_req is ignored in FAULT.
- vend_req while busy: ignored, no ack. A request still held on return to IDLE is accepted as new, so the FSM must drop vend_req after vend_ack.
- vend_req and fault_clr together in FAULT: only the clear takes effect; the request is accepted in the following IDLE cycle if still held.
- col_rise and timeout expiry in the same cycle: col_rise wins (done, not fault).
- vend_sel changes after acceptance have no effect on the running vend.
- Counters are sized with $clog2(param+1) and saturate; they never wrap.
- Outputs are registered. At most one motor_on bit is ever high.

Test Plan:
- Reset: rst=0 mid-SPIN (sel=2) -> motor_on=0000 asynchronously, state_dbg=0; after release, idle with all outputs 0.
- Normal vend: vend_req=1, sel=2'b10; drop after ack -> vend_ack 1 cycle later; motor_on=0100 for exactly 50 cycles; state_dbg=2; collected raised 10 cycles later -> vend_done 7 cycles after the raw edge; state_dbg=0.
- Early collect: collected held high through SPIN -> no vend_done; after collected drops and re-rises (debounced) -> vend_done pulse.
- Glitch rejection: collected high for 3 cycles in WAIT_COLLECT -> no vend_done. Held 6 cycles -> vend_done.
- Timeout: no collected for 1000 cycles after SPIN -> vend_fault=1, state_dbg=3; vend_req ignored; fault_clr pulse -> vend_fault=0, state_dbg=0.
- Busy reject: second vend_req (sel=0) during SPIN -> no second ack, motor_on unchanged (0100).
